// File: rtl/packet_filter_inst_loader.sv
// Assembles 64-bit BPF instructions from inst_low/inst_high strobes and writes them to instruction memory.
// Latency: high strobe to inst_wr_en is 1 cycle; write completion to next accepted high strobe is 1 cycle.
// Backpressure: inst_wr_en/addr/data hold until inst_wr_ready; strobes arriving while busy are dropped and flagged.
module packet_filter_inst_loader #(
  parameter int INST_ADDR_WIDTH = 10,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [31:0]                inst_low_value,
  input  logic                       inst_low_strobe,
  input  logic [31:0]                inst_high_value,
  input  logic                       inst_high_strobe,
  input  logic                       control_start,
  input  logic                       status_read_strobe,
  input  logic                       packet_dropped,
  output logic [DROP_CNT_WIDTH-1:0]  status_num_packets_dropped,
  output logic                       inst_wr_en,
  output logic [INST_ADDR_WIDTH-1:0] inst_wr_addr,
  output logic [63:0]                inst_wr_data,
  input  logic                       inst_wr_ready,
  output logic                       filter_enable,
  output logic [INST_ADDR_WIDTH:0]   inst_count,
  output logic                       load_error
);

  // Memory holds exactly 2**INST_ADDR_WIDTH entries; inst_count is one bit wider so "full" is representable.
  localparam logic [INST_ADDR_WIDTH:0]  INST_DEPTH = (INST_ADDR_WIDTH+1)'(1) << INST_ADDR_WIDTH;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = {DROP_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                low_reg_q, low_reg_d;
  logic                       low_valid_q, low_valid_d;
  logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]                wr_data_q, wr_data_d;
  logic                       wr_en_q, wr_en_d;
  logic [INST_ADDR_WIDTH:0]   inst_count_q, inst_count_d;
  logic                       load_error_q, load_error_d;
  logic                       filter_enable_q, filter_enable_d;
  logic [DROP_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic mem_full;
  logic high_accept;
  logic any_strobe;

  assign mem_full    = (inst_count_q == INST_DEPTH);
  // A high strobe only turns into a write when a low half is pending and there is room.
  assign high_accept = inst_high_strobe && low_valid_q && !mem_full;
  assign any_strobe  = inst_low_strobe || inst_high_strobe;

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a high strobe in IDLE takes priority over starting the filter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_high_strobe) begin
          if (high_accept) begin
            state_d = ST_WRITE;
          end
        end else if (control_start) begin
          state_d = ST_RUN;
        end
      end
      ST_WRITE: begin
        if (inst_wr_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!control_start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and loader datapath next values.
  always_comb begin
    low_reg_d       = low_reg_q;
    low_valid_d     = low_valid_q;
    addr_d          = addr_q;
    wr_data_d       = wr_data_q;
    wr_en_d         = wr_en_q;
    inst_count_d    = inst_count_q;
    load_error_d    = load_error_q;
    filter_enable_d = (state_q == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        // The high strobe is judged against the low half held before this cycle.
        if (inst_high_strobe) begin
          low_valid_d = 1'b0;
          if (high_accept) begin
            wr_data_d = {inst_high_value, low_reg_q};
            wr_en_d   = 1'b1;
          end else begin
            load_error_d = 1'b1;
          end
        end
        // A concurrent low strobe then becomes the pending half of the next instruction.
        if (inst_low_strobe) begin
          low_reg_d   = inst_low_value;
          low_valid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (any_strobe) begin
          load_error_d = 1'b1;
        end
        if (inst_wr_ready) begin
          addr_d       = addr_q + INST_ADDR_WIDTH'(1);
          inst_count_d = inst_count_q + (INST_ADDR_WIDTH+1)'(1);
          wr_en_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (any_strobe) begin
          load_error_d = 1'b1;
        end
        // Stopping the filter opens a fresh programming session; the clear wins over a same-cycle strobe.
        if (!control_start) begin
          addr_d       = '0;
          inst_count_d = '0;
          low_valid_d  = 1'b0;
          load_error_d = 1'b0;
        end
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  // Loader datapath registers; reset abandons any outstanding write.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      low_reg_q       <= '0;
      low_valid_q     <= 1'b0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      wr_en_q         <= 1'b0;
      inst_count_q    <= '0;
      load_error_q    <= 1'b0;
      filter_enable_q <= 1'b0;
    end else begin
      low_reg_q       <= low_reg_d;
      low_valid_q     <= low_valid_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      wr_en_q         <= wr_en_d;
      inst_count_q    <= inst_count_d;
      load_error_q    <= load_error_d;
      filter_enable_q <= filter_enable_d;
    end
  end

  // Dropped-packet counter: saturating, cleared after a Status read, with a same-cycle drop counted as 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (status_read_strobe) begin
      drop_cnt_d = packet_dropped ? DROP_CNT_WIDTH'(1) : '0;
    end else if (packet_dropped && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  // Dropped-packet counter register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign status_num_packets_dropped = drop_cnt_q;
  assign inst_wr_en                 = wr_en_q;
  assign inst_wr_addr               = addr_q;
  assign inst_wr_data               = wr_data_q;
  assign filter_enable              = filter_enable_q;
  assign inst_count                 = inst_count_q;
  assign load_error                 = load_error_q;

endmodule

// File: tb/tb_packet_filter_inst_loader.sv
// Directed bench for packet_filter_inst_loader: instruction loading, backpressure, errors, run/stop, drop counter, reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Completed memory writes are logged by a small monitor at the rising edge.
module tb_packet_filter_inst_loader;
  localparam int IAW = 10;
  localparam int DCW = 16;
  localparam int DEPTH = 1 << IAW;

  logic           axi_aclk;
  logic           axi_aresetn;
  logic [31:0]    inst_low_value;
  logic           inst_low_strobe;
  logic [31:0]    inst_high_value;
  logic           inst_high_strobe;
  logic           control_start;
  logic           status_read_strobe;
  logic           packet_dropped;
  logic [DCW-1:0] status_num_packets_dropped;
  logic           inst_wr_en;
  logic [IAW-1:0] inst_wr_addr;
  logic [63:0]    inst_wr_data;
  logic           inst_wr_ready;
  logic           filter_enable;
  logic [IAW:0]   inst_count;
  logic           load_error;

  int total = 0;
  int bad   = 0;

  int             wr_cnt = 0;
  logic [IAW-1:0] last_addr = '0;
  logic [63:0]    last_data = '0;
  logic [IAW-1:0] addr_log [0:2];

  packet_filter_inst_loader #(.INST_ADDR_WIDTH(IAW), .DROP_CNT_WIDTH(DCW)) dut (
    .axi_aclk(axi_aclk),
    .axi_aresetn(axi_aresetn),
    .inst_low_value(inst_low_value),
    .inst_low_strobe(inst_low_strobe),
    .inst_high_value(inst_high_value),
    .inst_high_strobe(inst_high_strobe),
    .control_start(control_start),
    .status_read_strobe(status_read_strobe),
    .packet_dropped(packet_dropped),
    .status_num_packets_dropped(status_num_packets_dropped),
    .inst_wr_en(inst_wr_en),
    .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data),
    .inst_wr_ready(inst_wr_ready),
    .filter_enable(filter_enable),
    .inst_count(inst_count),
    .load_error(load_error)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // Write monitor: records every accepted memory write.
  always @(posedge axi_aclk) begin
    if (axi_aresetn && inst_wr_en && inst_wr_ready) begin
      if (wr_cnt < 3) addr_log[wr_cnt] <= inst_wr_addr;
      wr_cnt    <= wr_cnt + 1;
      last_addr <= inst_wr_addr;
      last_data <= inst_wr_data;
    end
  end

  task automatic send_pair(input logic [31:0] lo, input logic [31:0] hi);
    @(negedge axi_aclk);
    inst_low_value  = lo;
    inst_low_strobe = 1'b1;
    @(negedge axi_aclk);
    inst_low_strobe  = 1'b0;
    inst_high_value  = hi;
    inst_high_strobe = 1'b1;
    @(negedge axi_aclk);
    inst_high_strobe = 1'b0;
  endtask

  // Run then stop the filter to start a fresh programming session.
  task automatic clear_session();
    @(negedge axi_aclk);
    control_start = 1'b1;
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    control_start = 1'b0;
    @(negedge axi_aclk);
    @(negedge axi_aclk);
  endtask

  task automatic test_reset();
    axi_aresetn = 1'b0;
    inst_low_value = '0; inst_low_strobe = 1'b0;
    inst_high_value = '0; inst_high_strobe = 1'b0;
    control_start = 1'b0; status_read_strobe = 1'b0;
    packet_dropped = 1'b0; inst_wr_ready = 1'b1;
    repeat (3) @(negedge axi_aclk);
    total++;
    if ({inst_wr_en, inst_wr_addr, inst_wr_data, filter_enable, inst_count, load_error, status_num_packets_dropped} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%0b addr=%0d data=%h fe=%0b cnt=%0d err=%0b drop=%0d, required all 0",
               inst_wr_en, inst_wr_addr, inst_wr_data, filter_enable, inst_count, load_error, status_num_packets_dropped);
    end
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
  endtask

  task automatic test_three_inst();
    inst_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_pair(32'h1111_1111, 32'hAAAA_AAAA);
      total++;
      if (inst_wr_en !== 1'b1 || inst_wr_addr !== IAW'(i) || inst_wr_data !== 64'hAAAA_AAAA_1111_1111) begin
        bad++;
        $display("FAIL three_write_%0d: en=%0b addr=%0d data=%h, required en=1 addr=%0d data=aaaaaaaa11111111",
                 i, inst_wr_en, inst_wr_addr, inst_wr_data, i);
      end
      @(negedge axi_aclk);
      total++;
      if (inst_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL three_en_drop_%0d: en=%0b, required 0", i, inst_wr_en);
      end
    end
    total++;
    if (wr_cnt !== 3 || addr_log[0] !== 0 || addr_log[1] !== 1 || addr_log[2] !== 2) begin
      bad++;
      $display("FAIL three_log: writes=%0d addrs=%0d,%0d,%0d, required 3 writes at 0,1,2",
               wr_cnt, addr_log[0], addr_log[1], addr_log[2]);
    end
    total++;
    if (inst_count !== 11'd3 || load_error !== 1'b0) begin
      bad++;
      $display("FAIL three_count: cnt=%0d err=%0b, required cnt=3 err=0", inst_count, load_error);
    end
  endtask

  task automatic test_run_stop();
    int base;
    @(negedge axi_aclk);
    control_start = 1'b1;
    @(negedge axi_aclk);
    total++;
    if (filter_enable !== 1'b0) begin
      bad++;
      $display("FAIL run_fe_entry: fe=%0b, required 0 on the entry cycle", filter_enable);
    end
    @(negedge axi_aclk);
    total++;
    if (filter_enable !== 1'b1) begin
      bad++;
      $display("FAIL run_fe_on: fe=%0b, required 1", filter_enable);
    end
    base = wr_cnt;
    inst_low_strobe = 1'b1;
    inst_high_strobe = 1'b1;
    @(negedge axi_aclk);
    inst_low_strobe = 1'b0;
    inst_high_strobe = 1'b0;
    total++;
    if (load_error !== 1'b1 || inst_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL run_strobe_err: err=%0b en=%0b, required err=1 en=0", load_error, inst_wr_en);
    end
    control_start = 1'b0;
    @(negedge axi_aclk);
    total++;
    if (inst_count !== 11'd0 || load_error !== 1'b0 || filter_enable !== 1'b1) begin
      bad++;
      $display("FAIL stop_clear: cnt=%0d err=%0b fe=%0b, required cnt=0 err=0 fe=1", inst_count, load_error, filter_enable);
    end
    @(negedge axi_aclk);
    total++;
    if (filter_enable !== 1'b0) begin
      bad++;
      $display("FAIL stop_fe_off: fe=%0b, required 0", filter_enable);
    end
    send_pair(32'h0000_0042, 32'h0000_0099);
    total++;
    if (inst_wr_addr !== 0 || inst_wr_data !== 64'h0000_0099_0000_0042 || inst_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL stop_next_addr: en=%0b addr=%0d data=%h, required en=1 addr=0 data=0000009900000042",
               inst_wr_en, inst_wr_addr, inst_wr_data);
    end
    @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base + 1 || last_addr !== 0) begin
      bad++;
      $display("FAIL stop_next_log: writes=%0d last_addr=%0d, required %0d writes last_addr=0", wr_cnt, last_addr, base + 1);
    end
  endtask

  task automatic test_backpressure();
    int base;
    clear_session();
    base = wr_cnt;
    inst_wr_ready = 1'b0;
    send_pair(32'h2222_2222, 32'hBBBB_BBBB);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (inst_wr_en !== 1'b1 || inst_wr_addr !== 0 || inst_wr_data !== 64'hBBBB_BBBB_2222_2222) begin
        bad++;
        $display("FAIL stall_hold_%0d: en=%0b addr=%0d data=%h, required en=1 addr=0 data=bbbbbbbb22222222",
                 i, inst_wr_en, inst_wr_addr, inst_wr_data);
      end
      inst_high_value  = 32'hDEAD_BEEF;
      inst_high_strobe = (i == 1);
      @(negedge axi_aclk);
    end
    inst_high_strobe = 1'b0;
    total++;
    if (load_error !== 1'b1 || wr_cnt !== base) begin
      bad++;
      $display("FAIL stall_err: err=%0b writes=%0d, required err=1 writes=%0d", load_error, wr_cnt, base);
    end
    inst_wr_ready = 1'b1;
    @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base + 1 || inst_wr_en !== 1'b0 || inst_count !== 11'd1 || last_data !== 64'hBBBB_BBBB_2222_2222) begin
      bad++;
      $display("FAIL stall_release: writes=%0d en=%0b cnt=%0d data=%h, required writes=%0d en=0 cnt=1 data=bbbbbbbb22222222",
               wr_cnt, inst_wr_en, inst_count, last_data, base + 1);
    end
    repeat (2) @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base + 1 || inst_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_extra: writes=%0d en=%0b, required writes=%0d en=0", wr_cnt, inst_wr_en, base + 1);
    end
  endtask

  task automatic test_protocol_errors();
    int base;
    clear_session();
    base = wr_cnt;
    @(negedge axi_aclk);
    inst_high_value  = 32'h5555_5555;
    inst_high_strobe = 1'b1;
    @(negedge axi_aclk);
    inst_high_strobe = 1'b0;
    total++;
    if (load_error !== 1'b1 || inst_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL no_low_err: err=%0b en=%0b, required err=1 en=0", load_error, inst_wr_en);
    end
    @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base || inst_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL no_low_write: writes=%0d en=%0b, required writes=%0d en=0", wr_cnt, inst_wr_en, base);
    end
    clear_session();
    base = wr_cnt;
    inst_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      send_pair(32'(i), 32'hC0DE_0000 | 32'(i));
      @(negedge axi_aclk);
    end
    total++;
    if (inst_count !== 11'(DEPTH) || load_error !== 1'b0 || wr_cnt !== base + DEPTH || last_addr !== IAW'(DEPTH - 1)) begin
      bad++;
      $display("FAIL fill: cnt=%0d err=%0b writes=%0d last_addr=%0d, required cnt=%0d err=0 writes=%0d last_addr=%0d",
               inst_count, load_error, wr_cnt - base, last_addr, DEPTH, DEPTH, DEPTH - 1);
    end
    send_pair(32'h7777_7777, 32'h8888_8888);
    total++;
    if (load_error !== 1'b1 || inst_wr_en !== 1'b0 || inst_count !== 11'(DEPTH)) begin
      bad++;
      $display("FAIL full_err: err=%0b en=%0b cnt=%0d, required err=1 en=0 cnt=%0d", load_error, inst_wr_en, inst_count, DEPTH);
    end
    @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base + DEPTH) begin
      bad++;
      $display("FAIL full_no_write: writes=%0d, required %0d", wr_cnt - base, DEPTH);
    end
  endtask

  task automatic test_drop_counter();
    @(negedge axi_aclk);
    total++;
    if (status_num_packets_dropped !== 16'd0) begin
      bad++;
      $display("FAIL drop_start: cnt=%0d, required 0", status_num_packets_dropped);
    end
    packet_dropped = 1'b1;
    repeat (3) @(negedge axi_aclk);
    packet_dropped = 1'b0;
    total++;
    if (status_num_packets_dropped !== 16'd3) begin
      bad++;
      $display("FAIL drop_three: cnt=%0d, required 3", status_num_packets_dropped);
    end
    status_read_strobe = 1'b1;
    @(negedge axi_aclk);
    status_read_strobe = 1'b0;
    total++;
    if (status_num_packets_dropped !== 16'd0) begin
      bad++;
      $display("FAIL read_clear: cnt=%0d, required 0", status_num_packets_dropped);
    end
    packet_dropped = 1'b1;
    repeat (70000) @(negedge axi_aclk);
    packet_dropped = 1'b0;
    total++;
    if (status_num_packets_dropped !== 16'hFFFF) begin
      bad++;
      $display("FAIL drop_saturate: cnt=%h, required ffff", status_num_packets_dropped);
    end
    status_read_strobe = 1'b1;
    packet_dropped = 1'b1;
    @(negedge axi_aclk);
    status_read_strobe = 1'b0;
    packet_dropped = 1'b0;
    total++;
    if (status_num_packets_dropped !== 16'd1) begin
      bad++;
      $display("FAIL read_and_drop: cnt=%0d, required 1", status_num_packets_dropped);
    end
    status_read_strobe = 1'b1;
    @(negedge axi_aclk);
    status_read_strobe = 1'b0;
    total++;
    if (status_num_packets_dropped !== 16'd0) begin
      bad++;
      $display("FAIL read_alone: cnt=%0d, required 0", status_num_packets_dropped);
    end
  endtask

  task automatic test_reset_mid_write();
    int base;
    clear_session();
    inst_wr_ready = 1'b1;
    send_pair(32'h0101_0101, 32'h0202_0202);
    @(negedge axi_aclk);
    inst_wr_ready = 1'b0;
    packet_dropped = 1'b1;
    send_pair(32'h0303_0303, 32'h0404_0404);
    packet_dropped = 1'b0;
    total++;
    if (inst_wr_en !== 1'b1 || inst_wr_addr !== 1 || status_num_packets_dropped === 16'd0) begin
      bad++;
      $display("FAIL pre_reset_state: en=%0b addr=%0d drop=%0d, required en=1 addr=1 drop nonzero",
               inst_wr_en, inst_wr_addr, status_num_packets_dropped);
    end
    #2 axi_aresetn = 1'b0;
    #1;
    total++;
    if ({inst_wr_en, inst_wr_addr, inst_wr_data, filter_enable, inst_count, load_error, status_num_packets_dropped} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: en=%0b addr=%0d data=%h fe=%0b cnt=%0d err=%0b drop=%0d, required all 0",
               inst_wr_en, inst_wr_addr, inst_wr_data, filter_enable, inst_count, load_error, status_num_packets_dropped);
    end
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    inst_wr_ready = 1'b1;
    base = wr_cnt;
    send_pair(32'h0505_0505, 32'h0606_0606);
    total++;
    if (inst_wr_en !== 1'b1 || inst_wr_addr !== 0 || inst_wr_data !== 64'h0606_0606_0505_0505) begin
      bad++;
      $display("FAIL post_reset_write: en=%0b addr=%0d data=%h, required en=1 addr=0 data=0606060605050505",
               inst_wr_en, inst_wr_addr, inst_wr_data);
    end
    @(negedge axi_aclk);
    total++;
    if (wr_cnt !== base + 1 || last_addr !== 0 || inst_count !== 11'd1) begin
      bad++;
      $display("FAIL post_reset_log: writes=%0d last_addr=%0d cnt=%0d, required writes=%0d last_addr=0 cnt=1",
               wr_cnt, last_addr, inst_count, base + 1);
    end
  endtask

  initial begin
    test_reset();
    test_three_inst();
    test_run_stop();
    test_backpressure();
    test_protocol_errors();
    test_drop_counter();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
